// File: rtl/seg_scan_driver.sv
// Time-multiplexed segment display driver with a shadow/display bank pair.
// Committed patterns move to the display bank only at a frame boundary.
module seg_scan_driver #(
    parameter int DIGITS       = 8,
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [2:0]        wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              commit,
    output logic              commit_pending,
    output logic [7:0]        seg_out,
    output logic [DIGITS-1:0] digit_sel,
    output logic              frame_start
);

    localparam int IDX_W = $clog2(DIGITS);
    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DIGITS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
    localparam logic [DIGITS-1:0] SEL_ONE  = DIGITS'(1);

    logic [CNT_W-1:0] slot_cnt;
    logic [IDX_W-1:0] idx;
    logic [7:0]       shadow [DIGITS];
    logic [7:0]       active [DIGITS];
    logic             pending;

    logic slot_end;
    logic frame_end;
    logic blank;
    logic wr_hit;

    assign slot_end  = (slot_cnt == LAST_CNT);
    assign frame_end = slot_end && (idx == LAST_IDX);
    assign blank     = (slot_cnt < BLANK_END);
    assign wr_hit    = wr_en && (int'(wr_addr) < DIGITS);

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt <= '0;
            idx      <= '0;
            pending  <= 1'b0;
            // NOTE: both banks are reset explicitly because the display must
            // come up dark; a bank left uninitialised would show garbage
            // after the first commit that precedes any write.
            for (int i = 0; i < DIGITS; i++) begin
                shadow[i] <= 8'h00;
                active[i] <= 8'h00;
            end
        end else begin
            if (slot_end) begin
                slot_cnt <= '0;
                idx      <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
            end else begin
                slot_cnt <= slot_cnt + CNT_W'(1);
            end

            if (wr_hit) begin
                shadow[wr_addr[IDX_W-1:0]] <= wr_data;
            end

            // NOTE: non-blocking assignment means active samples shadow as it
            // was before this edge, so a same-edge write stays in shadow only.
            if (frame_end && (pending || commit)) begin
                active  <= shadow;
                pending <= 1'b0;
            end else if (commit) begin
                pending <= 1'b1;
            end
        end
    end

    // Outputs decode registered state only; no input reaches them directly.
    assign seg_out        = blank ? 8'h00 : active[idx];
    assign digit_sel      = blank ? '0 : (SEL_ONE << idx);
    assign frame_start    = (idx == '0) && (slot_cnt == '0);
    assign commit_pending = pending;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver (DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2).
// Stimulus pushes the expected post-edge outputs; a monitor compares them.
module tb_seg_scan_driver;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 8;
    localparam int BLANK    = 2;
    localparam int FRAME    = DIGITS * SCAN_DIV;

    typedef struct packed {
        logic [7:0] seg;
        logic [3:0] sel;
        logic       fs;
        logic       pend;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic        commit = 1'b0;
    logic        commit_pending;
    logic [7:0]  seg_out;
    logic [3:0]  digit_sel;
    logic        frame_start;

    int          checks = 0;
    int          errors = 0;
    int          pos    = 0;
    exp_t        sb_q[$];
    logic [7:0]  exp_disp [DIGITS];
    logic        exp_pend = 1'b0;
    bit          done = 1'b0;

    seg_scan_driver #(
        .DIGITS      (DIGITS),
        .SCAN_DIV    (SCAN_DIV),
        .BLANK_CYCLES(BLANK)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .commit        (commit),
        .commit_pending(commit_pending),
        .seg_out       (seg_out),
        .digit_sel     (digit_sel),
        .frame_start   (frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // One clock: drive inputs, take the edge, then queue the expected state.
    task automatic cycle(input logic r, input logic w, input logic [2:0] a,
                         input logic [7:0] d, input logic c);
        exp_t e;
        int   slot;
        int   dig;
        rst = r; wr_en = w; wr_addr = a; wr_data = d; commit = c;
        @(posedge clk);
        #1;
        rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; commit = 1'b0;
        pos  = r ? 0 : (pos + 1) % FRAME;
        slot = pos % SCAN_DIV;
        dig  = pos / SCAN_DIV;
        e.seg  = (slot < BLANK) ? 8'h00 : exp_disp[dig];
        e.sel  = (slot < BLANK) ? 4'b0000 : 4'(1 << dig);
        e.fs   = (pos == 0);
        e.pend = exp_pend;
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
    endtask

    task automatic run_to(input int p);
        while (pos != p) cycle(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("seg_out",        seg_out,               e.seg);
                check("digit_sel",      {4'b0, digit_sel},     {4'b0, e.sel});
                check("frame_start",    {7'b0, frame_start},   {7'b0, e.fs});
                check("commit_pending", {7'b0, commit_pending}, {7'b0, e.pend});
            end
        end
    end

    initial begin : stimulus
        for (int i = 0; i < DIGITS; i++) exp_disp[i] = 8'h00;

        // Reset and idle scan: all dark, enables still rotate.
        cycle(1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
        idle(40);

        // Two writes then a mid-frame commit; copy lands on the boundary.
        run_to(1);
        cycle(1'b0, 1'b1, 3'd0, 8'hFC, 1'b0);
        cycle(1'b0, 1'b1, 3'd2, 8'hDA, 1'b0);
        run_to(5);
        exp_pend = 1'b1;
        cycle(1'b0, 1'b0, 3'd0, 8'h00, 1'b1);
        run_to(FRAME - 1);
        exp_pend    = 1'b0;
        exp_disp[0] = 8'hFC;
        exp_disp[2] = 8'hDA;
        cycle(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        idle(FRAME);

        // Write without commit: display untouched for three frames.
        cycle(1'b0, 1'b1, 3'd1, 8'h60, 1'b0);
        idle(3 * FRAME);

        // Commit plus write on the boundary cycle: digit 3 keeps its old value.
        run_to(FRAME - 1);
        exp_disp[1] = 8'h60;
        cycle(1'b0, 1'b1, 3'd3, 8'hFF, 1'b1);
        idle(FRAME);

        // Later commit, repeated while pending, brings FF in with one copy.
        run_to(4);
        exp_pend = 1'b1;
        cycle(1'b0, 1'b0, 3'd0, 8'h00, 1'b1);
        cycle(1'b0, 1'b0, 3'd0, 8'h00, 1'b1);
        run_to(FRAME - 1);
        exp_pend    = 1'b0;
        exp_disp[3] = 8'hFF;
        cycle(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        idle(FRAME);

        // Out-of-range address must not alias onto any digit.
        cycle(1'b0, 1'b1, 3'd5, 8'hAA, 1'b0);
        run_to(2);
        exp_pend = 1'b1;
        cycle(1'b0, 1'b0, 3'd0, 8'h00, 1'b1);
        run_to(FRAME - 1);
        exp_pend = 1'b0;
        cycle(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        idle(FRAME);

        // Reset mid-slot with a commit pending; a concurrent write is dropped.
        run_to(10);
        exp_pend = 1'b1;
        cycle(1'b0, 1'b0, 3'd0, 8'h00, 1'b1);
        run_to(13);
        exp_pend = 1'b0;
        for (int i = 0; i < DIGITS; i++) exp_disp[i] = 8'h00;
        cycle(1'b1, 1'b1, 3'd0, 8'h55, 1'b0);
        idle(40);

        // Commit after reset publishes the cleared shadow bank.
        run_to(3);
        exp_pend = 1'b1;
        cycle(1'b0, 1'b0, 3'd0, 8'h00, 1'b1);
        run_to(FRAME - 1);
        exp_pend = 1'b0;
        cycle(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        idle(FRAME);

        @(posedge clk);
        @(posedge clk);
        check("scoreboard_drained", 8'(sb_q.size()), 8'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
